// File: rtl/vector_sweeper_if.sv
// -----------------------------------------------------------------------------
// vector_sweeper_if
// Bundles the request, stimulus, response and status signals of the
// vector_sweeper so the block and its user connect through one port.
//
//   start     sweep request (sampled only while the sweeper is idle)
//   dwell     extra hold cycles per vector, latched when a sweep is accepted
//   exp_tt    expected truth table, bit i = expected y for vector i
//   abort     synchronous sweep cancel
//   a, b, c   stimulus bits of the current vector (a = MSB, c = LSB)
//   y_in      response of the combinational function under test
//   busy      high while a sweep is in progress
//   done      one-cycle completion pulse
//   result    captured truth table, bit i = y_in sampled for vector i
//   mismatch  final result differs from the latched exp_tt
//   err_cnt   number of differing truth-table bits, 0..8
//
// master: the side that requests sweeps and closes the loop through y_in.
// slave : the sweeper itself.
// -----------------------------------------------------------------------------
interface vector_sweeper_if;
  logic       start;
  logic [7:0] dwell;
  logic [7:0] exp_tt;
  logic       abort;
  logic       a;
  logic       b;
  logic       c;
  logic       y_in;
  logic       busy;
  logic       done;
  logic [7:0] result;
  logic       mismatch;
  logic [3:0] err_cnt;

  modport master (
    output start, dwell, exp_tt, abort, y_in,
    input  a, b, c, busy, done, result, mismatch, err_cnt
  );

  modport slave (
    input  start, dwell, exp_tt, abort, y_in,
    output a, b, c, busy, done, result, mismatch, err_cnt
  );
endinterface

// File: rtl/vector_sweeper.sv
// -----------------------------------------------------------------------------
// vector_sweeper
// Exhaustively drives the eight 3-bit input vectors {a,b,c} = 0..7 into an
// external combinational function, samples its response y_in once per
// vector, and compares the captured truth table with an expected one.
// Each vector is held for dwell+1 cycles; y_in is sampled on the last one.
//
// Ports:
//   clk   single clock, rising edge
//   rst   asynchronous, active-high reset
//   bus   vector_sweeper_if.slave (see the interface file for signal list)
//
// All outputs come straight from flops; mismatch and err_cnt are computed
// on the edge that enters DONE so they are valid together with done.
// -----------------------------------------------------------------------------
module vector_sweeper (
  input  logic             clk,
  input  logic             rst,
  vector_sweeper_if.slave  bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    DRIVE = 2'd1,
    DONE  = 2'd2
  } state_t;

  state_t     state;
  logic [2:0] vec;        // vector currently being driven
  logic [7:0] cnt;        // remaining extra hold cycles for this vector
  logic [7:0] dwell_q;
  logic [7:0] exp_q;
  logic [7:0] result_q;
  logic [2:0] stim_q;     // registered {a,b,c}
  logic       busy_q;
  logic       done_q;
  logic       mismatch_q;
  logic [3:0] err_cnt_q;

  // Truth table as it will stand after the last vector is sampled: the
  // final y_in lands in bit 7 on the same edge that enters DONE.
  logic [7:0] final_tt;
  logic [7:0] final_diff;

  assign final_tt   = {bus.y_in, result_q[6:0]};
  assign final_diff = final_tt ^ exp_q;

  function automatic logic [3:0] popcount8(input logic [7:0] v);
    logic [3:0] n;
    n = '0;
    for (int i = 0; i < 8; i++) begin
      n = n + {3'b000, v[i]};
    end
    return n;
  endfunction

  // NOTE: sequential state uses non-blocking assignments so every register
  // sees the pre-edge values of the others, independent of statement order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state      <= IDLE;
      vec        <= '0;
      cnt        <= '0;
      dwell_q    <= '0;
      exp_q      <= '0;
      result_q   <= '0;
      stim_q     <= '0;
      busy_q     <= 1'b0;
      done_q     <= 1'b0;
      mismatch_q <= 1'b0;
      err_cnt_q  <= '0;
    end else begin
      case (state)
        IDLE: begin
          done_q <= 1'b0;
          // abort wins over a simultaneous start
          if (bus.start && !bus.abort) begin
            state      <= DRIVE;
            vec        <= '0;
            cnt        <= bus.dwell;
            dwell_q    <= bus.dwell;
            exp_q      <= bus.exp_tt;
            result_q   <= '0;
            mismatch_q <= 1'b0;
            err_cnt_q  <= '0;
            stim_q     <= 3'b000;
            busy_q     <= 1'b1;
          end
        end

        DRIVE: begin
          if (bus.abort) begin
            // Partial result is kept; the vector in flight is not sampled.
            state  <= IDLE;
            vec    <= '0;
            cnt    <= '0;
            stim_q <= 3'b000;
            busy_q <= 1'b0;
          end else if (cnt != 8'd0) begin
            cnt <= cnt - 8'd1;
          end else begin
            result_q[vec] <= bus.y_in;
            cnt           <= dwell_q;
            if (vec == 3'd7) begin
              state      <= DONE;
              vec        <= '0;
              stim_q     <= 3'b000;
              busy_q     <= 1'b0;
              done_q     <= 1'b1;
              mismatch_q <= |final_diff;
              err_cnt_q  <= popcount8(final_diff);
            end else begin
              vec    <= vec + 3'd1;
              stim_q <= vec + 3'd1;
            end
          end
        end

        DONE: begin
          // Single-cycle state; start and abort are both ignored here.
          state  <= IDLE;
          done_q <= 1'b0;
        end

        default: begin
          state  <= IDLE;
          stim_q <= 3'b000;
          busy_q <= 1'b0;
          done_q <= 1'b0;
        end
      endcase
    end
  end

  assign bus.a        = stim_q[2];
  assign bus.b        = stim_q[1];
  assign bus.c        = stim_q[0];
  assign bus.busy     = busy_q;
  assign bus.done     = done_q;
  assign bus.result   = result_q;
  assign bus.mismatch = mismatch_q;
  assign bus.err_cnt  = err_cnt_q;

endmodule

// File: tb/tb_vector_sweeper.sv
// -----------------------------------------------------------------------------
// tb_vector_sweeper
// Directed bench for vector_sweeper. The function under test is
// y = ~b&~c | a&~b, evaluated continuously from the DUT stimulus. Expected
// sweep outcomes are pushed to a scoreboard when a sweep is requested and
// popped when done is seen. Outputs are sampled on the falling clock edge.
// -----------------------------------------------------------------------------
module tb_vector_sweeper;

  logic clk = 1'b0;
  logic rst;
  int   checks = 0;
  int   errors = 0;

  vector_sweeper_if bus ();

  vector_sweeper dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  always #5 clk = ~clk;

  // Closed-loop combinational function driven by the sweeper.
  assign bus.y_in = (~bus.b & ~bus.c) | (bus.a & ~bus.b);

  typedef struct {
    logic [7:0] result;
    logic       mismatch;
    logic [3:0] err_cnt;
  } exp_t;

  exp_t sb[$];

  // Reference truth table and comparison against the expected table.
  function automatic exp_t model(input logic [7:0] expected_tt);
    exp_t       e;
    logic [2:0] v;
    logic [7:0] tt;
    int         n;
    tt = '0;
    n  = 0;
    for (int i = 0; i < 8; i++) begin
      v     = i[2:0];
      tt[i] = (~v[1] & ~v[0]) | (v[2] & ~v[1]);
      if (tt[i] != expected_tt[i]) n++;
    end
    e.result   = tt;
    e.mismatch = (n != 0);
    e.err_cnt  = 4'(n);
    return e;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
    end
  endtask

  task automatic check_idle(input string tag);
    check({tag, "_busy"}, bus.busy, 0);
    check({tag, "_done"}, bus.done, 0);
    check({tag, "_abc"}, {bus.a, bus.b, bus.c}, 0);
  endtask

  // Requests a sweep and returns on the first DRIVE-cycle falling edge.
  task automatic start_sweep(input logic [7:0] dw, input logic [7:0] ex,
                             input bit expect_done, input string tag);
    @(negedge clk);
    bus.start  = 1'b1;
    bus.dwell  = dw;
    bus.exp_tt = ex;
    if (expect_done) sb.push_back(model(ex));
    @(negedge clk);
    bus.start = 1'b0;
    check({tag, "_accept_busy"}, bus.busy, 1);
    check({tag, "_accept_result_clr"}, bus.result, 0);
  endtask

  // Follows a sweep from its first DRIVE cycle through DONE into IDLE,
  // checking the vector sequence, busy length and the scoreboard entry.
  task automatic run_to_done(input int dw, input string tag);
    int   k = 0;
    int   busy_cycles = 0;
    exp_t e;
    while (bus.done !== 1'b1 && k < 3000) begin
      if (bus.busy === 1'b1) begin
        check($sformatf("%s_abc_%0d", tag, busy_cycles),
              {29'd0, bus.a, bus.b, bus.c}, busy_cycles / (dw + 1));
        busy_cycles++;
      end
      k++;
      @(negedge clk);
    end
    check({tag, "_done_seen"}, bus.done, 1);
    check({tag, "_busy_len"}, busy_cycles, 8 * (dw + 1));
    check({tag, "_busy_at_done"}, bus.busy, 0);
    check({tag, "_abc_at_done"}, {bus.a, bus.b, bus.c}, 0);
    check({tag, "_sb_nonempty"}, sb.size() != 0, 1);
    if (sb.size() != 0) begin
      e = sb.pop_front();
      check({tag, "_result"}, bus.result, e.result);
      check({tag, "_mismatch"}, bus.mismatch, e.mismatch);
      check({tag, "_err_cnt"}, bus.err_cnt, e.err_cnt);
      @(negedge clk);
      check_idle({tag, "_after"});
      check({tag, "_result_hold"}, bus.result, e.result);
      check({tag, "_err_cnt_hold"}, bus.err_cnt, e.err_cnt);
    end else begin
      @(negedge clk);
    end
  endtask

  initial begin
    int   done_hits;
    exp_t e;

    bus.start  = 1'b0;
    bus.abort  = 1'b0;
    bus.dwell  = 8'd0;
    bus.exp_tt = 8'd0;
    rst        = 1'b1;
    #1;
    check_idle("reset");
    check("reset_result", bus.result, 0);
    check("reset_mismatch", bus.mismatch, 0);
    check("reset_err_cnt", bus.err_cnt, 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;

    // Matching truth table, no dwell.
    start_sweep(8'd0, 8'h31, 1, "match");
    run_to_done(0, "match");

    // Fully inverted expectation.
    start_sweep(8'd0, 8'hCE, 1, "inv");
    run_to_done(0, "inv");

    // Single-bit disagreement in the last vector.
    start_sweep(8'd0, 8'hB1, 1, "one_bit");
    run_to_done(0, "one_bit");

    // dwell=3; inputs changed right after acceptance must be ignored.
    start_sweep(8'd3, 8'h31, 1, "dwell3");
    bus.dwell  = 8'd0;
    bus.exp_tt = 8'h00;
    run_to_done(3, "dwell3");

    // Abort on the third DRIVE cycle.
    start_sweep(8'd0, 8'h31, 0, "abort");
    @(negedge clk);
    @(negedge clk);
    check("abort_vec2", {bus.a, bus.b, bus.c}, 3'd2);
    bus.abort = 1'b1;
    @(negedge clk);
    bus.abort = 1'b0;
    check_idle("abort_next");
    check("abort_partial_result", bus.result, 8'h01);
    done_hits = 0;
    repeat (12) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_hits++;
    end
    check("abort_no_done", done_hits, 0);

    // abort together with start in IDLE: nothing starts.
    bus.start = 1'b1;
    bus.abort = 1'b1;
    @(negedge clk);
    bus.start = 1'b0;
    bus.abort = 1'b0;
    check_idle("abort_start_idle");
    check("abort_start_result", bus.result, 8'h01);

    // start held high: back-to-back sweeps with DONE then IDLE in between.
    bus.start  = 1'b1;
    bus.dwell  = 8'd0;
    bus.exp_tt = 8'h31;
    sb.push_back(model(8'h31));
    sb.push_back(model(8'h31));
    @(negedge clk);
    check("b2b1_accept_busy", bus.busy, 1);
    run_to_done(0, "b2b1");
    @(negedge clk);
    bus.start = 1'b0;
    check("b2b2_accept_busy", bus.busy, 1);
    run_to_done(0, "b2b2");

    // Maximum dwell.
    start_sweep(8'd255, 8'h30, 1, "dwell255");
    run_to_done(255, "dwell255");

    // Asynchronous reset mid-sweep.
    start_sweep(8'd1, 8'h31, 1, "rst_mid");
    repeat (3) @(negedge clk);
    check("rst_mid_pre_result", bus.result, 8'h01);
    #2;
    rst = 1'b1;
    #1;
    check_idle("rst_mid_async");
    check("rst_mid_result", bus.result, 0);
    check("rst_mid_mismatch", bus.mismatch, 0);
    check("rst_mid_err_cnt", bus.err_cnt, 0);
    sb.delete();
    @(negedge clk);
    rst = 1'b0;
    done_hits = 0;
    repeat (10) begin
      @(negedge clk);
      if (bus.done === 1'b1 || bus.busy === 1'b1) done_hits++;
    end
    check("rst_mid_no_done", done_hits, 0);

    // A full sweep after the reset.
    start_sweep(8'd0, 8'hCE, 1, "post_rst");
    run_to_done(0, "post_rst");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/vector_sweeper.md
VECTOR_SWEEPER -- requirements
Module: vector_sweeper

Interface
REQ-001 The block SHALL have no parameters; all widths SHALL be fixed as listed below.
REQ-002 clk  input  1  single clock; all state SHALL update on the rising edge.
REQ-003 rst  input  1  asynchronous, active-high reset.
REQ-004 start  input  1  sweep request, sampled in IDLE only.
REQ-005 dwell  input  8  extra hold cycles per vector, latched at accepted start.
REQ-006 exp_tt  input  8  expected truth table, bit i = expected y for vector i, latched at accepted start.
REQ-007 abort  input  1  synchronous sweep cancel.
REQ-008 a  output  1  stimulus to the consuming function, MSB of the current vector.
REQ-009 b  output  1  stimulus, middle bit of the current vector.
REQ-010 c  output  1  stimulus, LSB of the current vector.
REQ-011 y_in  input  1  response of the driven combinational function.
REQ-012 busy  output  1  high while a sweep is in progress.
REQ-013 done  output  1  one-cycle completion pulse.
REQ-014 result  output  8  captured truth table, bit i = y_in sampled for vector i.
REQ-015 mismatch  output  1  high when the final result differs from the latched exp_tt.
REQ-016 err_cnt  output  4  popcount of (result XOR latched exp_tt), range 0..8.

Function
REQ-017 The FSM SHALL have exactly three states: IDLE, DRIVE and DONE.
REQ-018 In IDLE, start=1 SHALL move the FSM to DRIVE on the next edge, with vec=0, hold counter=dwell, result=0, and dwell and exp_tt latched.
REQ-019 {a,b,c} SHALL equal vec[2:0] in DRIVE and SHALL be 3'b000 in IDLE and DONE.
REQ-020 In DRIVE, each vector SHALL be held for dwell+1 cycles, with the counter decrementing every cycle while non-zero.
REQ-021 In DRIVE, when the counter is 0, y_in SHALL be written into result[vec] on that edge, vec SHALL increment, and the counter SHALL reload with the latched dwell.
REQ-022 After vec=7 has been sampled, the FSM SHALL enter DONE; with dwell=0 a sweep SHALL occupy exactly 8 DRIVE cycles.
REQ-023 DONE SHALL last one cycle with done=1, and the FSM SHALL then return to IDLE unconditionally.
REQ-024 busy SHALL be 1 exactly while the FSM is in DRIVE.
REQ-025 mismatch and err_cnt SHALL be registered on the DRIVE->DONE edge from the final result, so they are valid together with done.
REQ-026 result, mismatch and err_cnt SHALL hold their values until the next accepted start.
REQ-027 start while busy or in DONE SHALL be ignored, with no queuing.
REQ-028 The latched dwell and exp_tt SHALL remain stable during a sweep, and input changes mid-sweep SHALL have no effect.
REQ-029 abort=1 in DRIVE SHALL force IDLE on the next edge, with no done pulse, partial result retained, and mismatch and err_cnt unchanged.
REQ-030 If abort and start are both 1 in IDLE, abort SHALL take priority and no sweep SHALL start.
REQ-031 abort in IDLE or DONE SHALL have no effect.
REQ-032 The maximum dwell=255 SHALL give 256 cycles per vector, and the counter SHALL never wrap.

Reset
REQ-033 rst=1 SHALL immediately, without a clock, force IDLE, vec=0, counter=0, a=b=c=0, busy=0, done=0, result=0, mismatch=0 and err_cnt=0.
REQ-034 Reset asserted mid-sweep SHALL discard the sweep, and no done SHALL follow.
REQ-035 After rst deasserts, the first start SHALL be accepted on the next rising edge.

Verification
REQ-036 With y_in driven by y=~b&~c | a&~b, dwell=0, exp_tt=8'h31, and start pulsed -> 8 busy cycles, done pulse, result=8'h31, mismatch=0, err_cnt=0.
REQ-037 The same setup with exp_tt=8'hCE -> result=8'h31, mismatch=1, err_cnt=8.
REQ-038 dwell=3 -> each {a,b,c} value held 4 cycles, busy high for 32 cycles, and result=8'h31.
REQ-039 abort asserted on the 3rd DRIVE cycle with dwell=0 -> IDLE next cycle, no done, result[1:0] captured, and result[7:2]=0.
REQ-040 start held high continuously -> back-to-back sweeps with one DONE cycle and one IDLE cycle between busy periods, with no start accepted while busy.
REQ-041 rst pulsed asynchronously mid-sweep -> all outputs 0 immediately, and a following start runs a complete sweep.
